// File: rtl/typedefs.sv
// Shared opcode/state encodings for the accumulator CPU.
package typedefs;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode of (ps, opcode, zero) into the seven datapath strobes.
module cpu_ctrl_decode
    import typedefs::*;
(
    input  state_t  ps,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr
);

    logic aluop;
    assign aluop = is_aluop(opcode);

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (ps)
            INST_ADDR: ;
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: mem_rd = aluop;
            ALU_OP: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-state instruction sequencer; optional sticky halt when CPU_HALT_LATCH_EN is defined.
module cpu_sequencer
    import typedefs::*;
(
    input  logic    clk,
    input  logic    rst_,
    input  opcode_t opcode,
    input  logic    zero,
    output state_t  ps,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr
);

    state_t ps_d;
    logic   halt_dec;
    logic   inc_pc_dec;

    cpu_ctrl_decode u_decode (
        .ps      (ps),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt_dec),
        .inc_pc  (inc_pc_dec),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr)
    );

`ifdef CPU_HALT_LATCH_EN
    logic halted_q;
    logic halted_d;

    always_comb begin
        halted_d = halted_q || ((ps == OP_ADDR) && (opcode == HLT));
        // Parking in OP_ADDR keeps the machine stopped until reset.
        ps_d     = halted_d ? OP_ADDR : state_t'(ps + 3'd1);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ps       <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            ps       <= ps_d;
            halted_q <= halted_d;
        end
    end

    assign halt   = halt_dec | halted_q;
    assign inc_pc = inc_pc_dec & ~halted_q;
`else
    always_comb begin
        ps_d = state_t'(ps + 3'd1);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ps <= INST_ADDR;
        end else begin
            ps <= ps_d;
        end
    end

    assign halt   = halt_dec;
    assign inc_pc = inc_pc_dec;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; strobe vectors are {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr}.
module tb_cpu_sequencer;
    import typedefs::*;

    logic    clk;
    logic    rst_;
    opcode_t opcode;
    logic    zero;
    state_t  ps;
    logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic [6:0] strobes;

    int checks;
    int failures;

    cpu_sequencer dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
        .ps      (ps),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr)
    );

    assign strobes = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects ps==INST_ADDR on entry; exp holds state 0 in its top 7 bits.
    task automatic run_instr(input string name, input opcode_t op, input logic z,
                             input logic [55:0] exp);
        opcode = op;
        zero   = z;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("%s_ps%0d", name, i), 32'(ps), 32'(i));
            check($sformatf("%s_strb%0d", name, i), 32'(strobes), 32'(exp[55-7*i -: 7]));
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        opcode   = ADD;
        zero     = 1'b0;
        rst_     = 1'b0;
        #12;
        check("reset_ps", 32'(ps), 32'(INST_ADDR));
        check("reset_strb", 32'(strobes), 32'h0);
        @(negedge clk);
        rst_ = 1'b1;

        run_instr("add", ADD, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100});
        run_instr("skz1", SKZ, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                      7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000});
        run_instr("skz0", SKZ, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                      7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000});
        run_instr("jmp", JMP, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b0000000, 7'b0000010, 7'b0001010});
        run_instr("sto", STO, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b0000000, 7'b0000000, 7'b0000001});
        run_instr("lda", LDA, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100});

        // Reset in the middle of a STO's STORE cycle.
        opcode = STO;
        repeat (7) @(negedge clk);
        #1;
        check("sto_mid_ps", 32'(ps), 32'(STORE));
        check("sto_mid_wr", 32'(mem_wr), 32'h1);
        rst_ = 1'b0;
        #1;
        check("rst_mid_wr", 32'(mem_wr), 32'h0);
        check("rst_mid_ps", 32'(ps), 32'(INST_ADDR));
        check("rst_mid_strb", 32'(strobes), 32'h0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        check("rel_first_edge", 32'(ps), 32'(INST_FETCH));
        repeat (7) @(negedge clk);
        check("rel_wrap", 32'(ps), 32'(INST_ADDR));

`ifdef CPU_HALT_LATCH_EN
        opcode = HLT;
        repeat (4) @(negedge clk);
        #1;
        check("hlt_ps", 32'(ps), 32'(OP_ADDR));
        check("hlt_strb_first", 32'(strobes), 32'b0011000);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("hlt_hold_ps%0d", i), 32'(ps), 32'(OP_ADDR));
            check($sformatf("hlt_hold_strb%0d", i), 32'(strobes), 32'b0010000);
        end
        opcode = ADD;
        rst_   = 1'b0;
        #1;
        check("hlt_rst_ps", 32'(ps), 32'(INST_ADDR));
        check("hlt_rst_strb", 32'(strobes), 32'h0);
        @(negedge clk);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);
        check("hlt_cleared_ps4", 32'(ps), 32'(OP_ADDR));
        check("hlt_cleared_halt", 32'(halt), 32'h0);
        @(negedge clk);
        check("hlt_cleared_ps5", 32'(ps), 32'(OP_FETCH));
`else
        run_instr("hlt", HLT, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0011000, 7'b0000000, 7'b0000000, 7'b0000000});
        check("hlt_next_ps", 32'(ps), 32'(INST_ADDR));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
